conv_read_sched: RTL and testbench
==================================

CONV_READ_SCHED -- requirements
Module: conv_read_sched

Interface
REQ-001 Params SHALL be: CH_NUM 4 (input channels, one weight address each); OC_NUM 4 (output channels, max 128); TILE_DIM 13 (output tiles per row/column); BANK_W 7 (block columns per bank row).
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  level/pulse; sampled only in IDLE.
REQ-006 dp_ready  in  1  datapath accepts an issue this cycle.
REQ-007 sram_raddr_a0..a3  out  6 each  group-A bank read addresses.
REQ-008 sram_raddr_weight  out  11  weight SRAM read address.
REQ-009 sram_raddr_bias  out  7  bias SRAM read address.
REQ-010 rd_valid  out  1  SRAM read data of the previous-cycle issue is present this cycle.
REQ-011 rd_first_ic / rd_last_ic  out  1 each  tag: ic==0 / ic==CH_NUM-1 for that data.
REQ-012 rd_oc  out  7;  rd_row, rd_col  out  4 each  tag: output channel and tile of that data.
REQ-013 busy  out  1  state != IDLE.
REQ-014 done  out  1  single-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, RUN, FLUSH, DONE: IDLE->RUN when start=1 (all counters cleared); RUN->FLUSH on acceptance of final issue; FLUSH->DONE; DONE->IDLE unconditionally.
REQ-016 An issue SHALL be accepted when state==RUN and dp_ready==1; counters advance only on acceptance.
REQ-017 Counter order SHALL be ic (innermost, 0..CH_NUM-1), col (0..TILE_DIM-1), row (0..TILE_DIM-1), oc (outermost, 0..OC_NUM-1), each wrapping to 0 and carrying into the next.
REQ-018 For tile (row,col), block (row+i,col+j), i,j in {0,1}, SHALL map to bank 2*((row+i)&1)+((col+j)&1) at address ((row+i)>>1)*BANK_W+((col+j)>>1); each bank receives exactly one block.
REQ-019 sram_raddr_weight SHALL equal oc*CH_NUM+ic; sram_raddr_bias SHALL equal oc; all addresses driven combinationally from registered counters, valid while in RUN.
REQ-020 When dp_ready==0 in RUN, all addresses and counters SHALL hold; rd_valid next cycle SHALL be 0.
REQ-021 rd_valid and all rd_* tags SHALL be registered copies of the accepted issue, latency exactly 1 cycle (matching SRAM read latency).
REQ-022 done SHALL be 1 only in DONE; busy high in RUN, FLUSH, DONE.
REQ-023 start while busy (RUN/FLUSH/DONE) SHALL be ignored.
REQ-024 Total accepted issues per run SHALL be CH_NUM*TILE_DIM*TILE_DIM*OC_NUM (2704 at defaults).
REQ-025 Outside RUN, all read addresses SHALL be 0.

Reset
REQ-026 rst=1 SHALL force IDLE, clear all counters, drive every output to 0 on the next edge, regardless of state, and take priority over start and dp_ready.
REQ-027 After reset mid-run, the next start SHALL restart from oc=0,row=0,col=0,ic=0 with no residual rd_valid.

Structure
REQ-028 Shared package SHALL hold FSM state encoding and the CH_NUM/OC_NUM/TILE_DIM/BANK_W defaults and the address widths (6/11/7), shared with the unshuffle and top blocks.
REQ-029 One sub-module SHALL be natural: tile_bank_map (combinational row/col -> four bank addresses per REQ-018).

Verification
REQ-030 Start, dp_ready=1: first issue a0..a3=0,0,0,0, weight 0, bias 0; tile (0,1) gives a0=1,a1=0,a2=1,a3=0; tile (12,12) gives all 48.
REQ-031 Start sampled at cycle 0, dp_ready=1: issues cycles 1..2704, rd_valid cycles 2..2705 (2704 pulses), done=1 only at cycle 2706, busy high cycles 1..2706.
REQ-032 Issue index 676: weight 4, bias 1, row=col=ic=0, rd_first_ic=1 next cycle; index 679: rd_last_ic=1.
REQ-033 dp_ready low 5 cycles mid-tile: addresses frozen, 5 rd_valid gaps, still 2704 pulses, done at cycle 2711.
REQ-034 start pulsed during RUN and in DONE: no restart, no count change; rst at issue 1000: IDLE next cycle, outputs 0, new start begins at all-zero addresses.

Source files
------------

// File: rtl/conv_read_sched_pkg.sv
// Shared constants, FSM encoding and read-tag layout for the convolution read scheduler.
package conv_read_sched_pkg;

    localparam int CH_NUM   = 4;
    localparam int OC_NUM   = 4;
    localparam int TILE_DIM = 13;
    localparam int BANK_W   = 7;

    localparam int BANK_AW   = 6;
    localparam int WEIGHT_AW = 11;
    localparam int BIAS_AW   = 7;

    localparam int IC_W   = 2;
    localparam int TILE_W = 4;
    localparam int OC_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Tag travelling one cycle behind each accepted issue, aligned with SRAM read data.
    typedef struct packed {
        logic              first_ic;
        logic              last_ic;
        logic [OC_W-1:0]   oc;
        logic [TILE_W-1:0] row;
        logic [TILE_W-1:0] col;
    } rd_tag_t;

endpackage

// File: rtl/conv_read_sched_tile_bank_map.sv
// Maps an output tile (row,col) to the read address of its 2x2 input blocks, one block per bank.
module conv_read_sched_tile_bank_map
    import conv_read_sched_pkg::*;
(
    input  logic [TILE_W-1:0]        row_i,
    input  logic [TILE_W-1:0]        col_i,
    output logic [3:0][BANK_AW-1:0]  addr_o
);

    // Bank b holds the block whose row parity is b[1] and column parity is b[0];
    // the tile's 2x2 window always contains exactly one such block.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        localparam bit ROW_PAR = (b / 2) != 0;
        localparam bit COL_PAR = (b % 2) != 0;

        logic [TILE_W:0] blk_row;
        logic [TILE_W:0] blk_col;

        assign blk_row = {1'b0, row_i} + {{TILE_W{1'b0}}, row_i[0] ^ ROW_PAR};
        assign blk_col = {1'b0, col_i} + {{TILE_W{1'b0}}, col_i[0] ^ COL_PAR};

        assign addr_o[b] = BANK_AW'(blk_row >> 1) * BANK_AW'(BANK_W) + BANK_AW'(blk_col >> 1);
    end

endmodule

// File: rtl/conv_read_sched.sv
// Walks ic/col/row/oc for one convolution pass, issuing bank, weight and bias SRAM reads with a 1-cycle tag.
module conv_read_sched
    import conv_read_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dp_ready,
    output logic [BANK_AW-1:0]   sram_raddr_a0,
    output logic [BANK_AW-1:0]   sram_raddr_a1,
    output logic [BANK_AW-1:0]   sram_raddr_a2,
    output logic [BANK_AW-1:0]   sram_raddr_a3,
    output logic [WEIGHT_AW-1:0] sram_raddr_weight,
    output logic [BIAS_AW-1:0]   sram_raddr_bias,
    output logic                 rd_valid,
    output logic                 rd_first_ic,
    output logic                 rd_last_ic,
    output logic [OC_W-1:0]      rd_oc,
    output logic [TILE_W-1:0]    rd_row,
    output logic [TILE_W-1:0]    rd_col,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    state_e              state_q, state_d;
    logic [IC_W-1:0]     ic_q, ic_d;
    logic [TILE_W-1:0]   col_q, col_d;
    logic [TILE_W-1:0]   row_q, row_d;
    logic [OC_W-1:0]     oc_q, oc_d;
    rd_tag_t             tag_q, tag_d;
    logic                rd_valid_q;

    logic                accept;
    logic                in_run;
    logic                ic_wrap, col_wrap, row_wrap, oc_wrap, last_issue;
    logic [3:0][BANK_AW-1:0] bank_addr;

    assign ic_wrap    = ic_q  == IC_W'(CH_NUM - 1);
    assign col_wrap   = col_q == TILE_W'(TILE_DIM - 1);
    assign row_wrap   = row_q == TILE_W'(TILE_DIM - 1);
    assign oc_wrap    = oc_q  == OC_W'(OC_NUM - 1);
    assign last_issue = ic_wrap & col_wrap & row_wrap & oc_wrap;

    // Handshake: an issue transfers on a cycle where state is RUN and dp_ready is high;
    // the presented addresses and counters hold otherwise, and rd_valid marks the cycle after transfer.
    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        col_d   = col_q;
        row_d   = row_q;
        oc_d    = oc_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ic_d  = '0;
                col_d = '0;
                row_d = '0;
                oc_d  = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (dp_ready) begin
                    accept = 1'b1;
                    ic_d   = ic_wrap ? '0 : ic_q + 1'b1;
                    if (ic_wrap) begin
                        col_d = col_wrap ? '0 : col_q + 1'b1;
                        if (col_wrap) begin
                            row_d = row_wrap ? '0 : row_q + 1'b1;
                            if (row_wrap) oc_d = oc_wrap ? '0 : oc_q + 1'b1;
                        end
                    end
                    if (last_issue) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d = '0;
        if (accept) begin
            tag_d.first_ic = ic_q == '0;
            tag_d.last_ic  = ic_wrap;
            tag_d.oc       = oc_q;
            tag_d.row      = row_q;
            tag_d.col      = col_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ic_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            oc_q       <= '0;
            tag_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ic_q       <= ic_d;
            col_q      <= col_d;
            row_q      <= row_d;
            oc_q       <= oc_d;
            tag_q      <= tag_d;
            rd_valid_q <= accept;
        end
    end

    conv_read_sched_tile_bank_map u_bank_map (
        .row_i  (row_q),
        .col_i  (col_q),
        .addr_o (bank_addr)
    );

    assign in_run = state_q == RUN;

    assign sram_raddr_a0     = in_run ? bank_addr[0] : '0;
    assign sram_raddr_a1     = in_run ? bank_addr[1] : '0;
    assign sram_raddr_a2     = in_run ? bank_addr[2] : '0;
    assign sram_raddr_a3     = in_run ? bank_addr[3] : '0;
    assign sram_raddr_weight = in_run ? WEIGHT_AW'(oc_q) * WEIGHT_AW'(CH_NUM) + WEIGHT_AW'(ic_q) : '0;
    assign sram_raddr_bias   = in_run ? BIAS_AW'(oc_q) : '0;

    assign rd_valid    = rd_valid_q;
    assign rd_first_ic = tag_q.first_ic;
    assign rd_last_ic  = tag_q.last_ic;
    assign rd_oc       = tag_q.oc;
    assign rd_row      = tag_q.row;
    assign rd_col      = tag_q.col;

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_read_sched.sv
// Self-checking bench for conv_read_sched: reference model drives a tag scoreboard and per-cycle address checks.
`timescale 1ns/1ps
module tb_conv_read_sched;
    import conv_read_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, dp_ready;
    logic [5:0]  sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3;
    logic [10:0] sram_raddr_weight;
    logic [6:0]  sram_raddr_bias;
    logic        rd_valid, rd_first_ic, rd_last_ic;
    logic [6:0]  rd_oc;
    logic [3:0]  rd_row, rd_col;
    logic        busy, done;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    conv_read_sched dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .dp_ready          (dp_ready),
        .sram_raddr_a0     (sram_raddr_a0),
        .sram_raddr_a1     (sram_raddr_a1),
        .sram_raddr_a2     (sram_raddr_a2),
        .sram_raddr_a3     (sram_raddr_a3),
        .sram_raddr_weight (sram_raddr_weight),
        .sram_raddr_bias   (sram_raddr_bias),
        .rd_valid          (rd_valid),
        .rd_first_ic       (rd_first_ic),
        .rd_last_ic        (rd_last_ic),
        .rd_oc             (rd_oc),
        .rd_row            (rd_row),
        .rd_col            (rd_col),
        .busy              (busy),
        .done              (done),
        .dbg_state         (dbg_state)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];
    logic        sb_on = 1'b0;
    logic        sb_exp_valid = 1'b0;

    state_e m_state = IDLE;
    int m_ic = 0, m_col = 0, m_row = 0, m_oc = 0;
    int cyc, pulses, done_cnt, done_cyc, busy_first, busy_last;

    logic [41:0] dut_addrs;
    logic [16:0] dut_tag;
    assign dut_addrs = {sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3,
                        sram_raddr_weight, sram_raddr_bias};
    assign dut_tag   = {rd_first_ic, rd_last_ic, rd_oc, rd_row, rd_col};

    // Enumerate the four blocks of the 2x2 window and pick the one landing in this bank.
    function automatic logic [5:0] model_bank_addr(int bank, int row, int col);
        logic [5:0] a;
        a = 6'd0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (((row + i) % 2) * 2 + ((col + j) % 2) == bank)
                    a = 6'(((row + i) / 2) * 7 + (col + j) / 2);
        return a;
    endfunction

    function automatic logic [41:0] model_addrs();
        if (m_state != RUN) return 42'd0;
        return {model_bank_addr(0, m_row, m_col), model_bank_addr(1, m_row, m_col),
                model_bank_addr(2, m_row, m_col), model_bank_addr(3, m_row, m_col),
                11'(m_oc * 4 + m_ic), 7'(m_oc)};
    endfunction

    // Scoreboard: addresses against the model every cycle, tags popped when valid is expected.
    always @(negedge clk) begin
        if (sb_on) begin
            logic [41:0] exp_a;
            logic [16:0] exp_t;
            exp_a = model_addrs();
            vectors++;
            if (dut_addrs !== exp_a) begin
                miscompares++;
                $display("FAIL addr_vec t=%0t got=%h exp=%h", $time, dut_addrs, exp_a);
            end
            vectors++;
            if (rd_valid !== sb_exp_valid) begin
                miscompares++;
                $display("FAIL rd_valid t=%0t got=%b exp=%b", $time, rd_valid, sb_exp_valid);
            end
            if (sb_exp_valid && exp_q.size() > 0) begin
                exp_t = exp_q.pop_front();
                vectors++;
                if (dut_tag !== exp_t) begin
                    miscompares++;
                    $display("FAIL rd_tag t=%0t got=%h exp=%h", $time, dut_tag, exp_t);
                end
            end
        end
    end

    task automatic clear_stats();
        cyc = 0; pulses = 0; done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    endtask

    // Driver: applies one cycle of inputs, predicts the DUT's next state and tallies observations.
    task automatic drive_cycle(input logic st, input logic rdy, input logic rs);
        logic acc, last;
        start = st; dp_ready = rdy; rst = rs;
        acc  = !rs && (m_state == RUN) && rdy;
        last = acc && m_ic == 3 && m_col == 12 && m_row == 12 && m_oc == 3;
        if (acc) exp_q.push_back({m_ic == 0, m_ic == 3, 7'(m_oc), 4'(m_row), 4'(m_col)});
        @(posedge clk);
        #1;
        cyc++;
        sb_exp_valid = acc;
        if (rs) begin
            m_state = IDLE; m_ic = 0; m_col = 0; m_row = 0; m_oc = 0;
        end else begin
            case (m_state)
                IDLE: if (st) begin
                    m_state = RUN; m_ic = 0; m_col = 0; m_row = 0; m_oc = 0;
                end
                RUN: if (acc) begin
                    if (last) m_state = FLUSH;
                    m_ic++;
                    if (m_ic == 4) begin
                        m_ic = 0; m_col++;
                        if (m_col == 13) begin
                            m_col = 0; m_row++;
                            if (m_row == 13) begin
                                m_row = 0; m_oc++;
                                if (m_oc == 4) m_oc = 0;
                            end
                        end
                    end
                end
                FLUSH:   m_state = DONE;
                DONE:    m_state = IDLE;
                default: m_state = IDLE;
            endcase
        end
        if (rd_valid === 1'b1) pulses++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (busy === 1'b1) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    endtask

    task automatic run_to_idle(input int stall_lo, input int stall_hi, input int start_cyc,
                               input bit start_in_done);
        for (int k = 0; k < 3000; k++) begin
            if (m_state == IDLE) break;
            drive_cycle((cyc == start_cyc) || (start_in_done && m_state == DONE),
                        !(cyc >= stall_lo && cyc <= stall_hi), 1'b0);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1);
        sb_on = 1'b1;
        vectors++;
        if ({busy, done, rd_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=000", {busy, done, rd_valid});
        end
        vectors++;
        if (dut_addrs !== 42'd0 || dut_tag !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h/%h exp=0/0", dut_addrs, dut_tag);
        end
        vectors++;
        if (dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_full_run();
        clear_stats();
        drive_cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2710; k++) begin
            if (m_state == IDLE) break;
            if (cyc == 1) begin
                vectors++;
                if (dut_addrs !== 42'd0) begin
                    miscompares++;
                    $display("FAIL first_issue got=%h exp=0", dut_addrs);
                end
            end
            if (cyc == 5) begin
                vectors++;
                if ({sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3} !== {6'd1, 6'd0, 6'd1, 6'd0}) begin
                    miscompares++;
                    $display("FAIL tile_0_1 got=%0d,%0d,%0d,%0d exp=1,0,1,0",
                             sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3);
                end
            end
            if (cyc == 673) begin
                vectors++;
                if ({sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3} !== {4{6'd48}}) begin
                    miscompares++;
                    $display("FAIL tile_12_12 got=%0d,%0d,%0d,%0d exp=48 each",
                             sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3);
                end
            end
            if (cyc == 677) begin
                vectors++;
                if (dut_addrs !== {24'd0, 11'd4, 7'd1}) begin
                    miscompares++;
                    $display("FAIL issue_676 got=%h exp=%h", dut_addrs, {24'd0, 11'd4, 7'd1});
                end
            end
            if (cyc == 678) begin
                vectors++;
                if ({rd_first_ic, rd_last_ic, rd_oc, rd_row, rd_col} !== {1'b1, 1'b0, 7'd1, 4'd0, 4'd0}) begin
                    miscompares++;
                    $display("FAIL tag_676 got=%h exp=%h", dut_tag, {1'b1, 1'b0, 7'd1, 4'd0, 4'd0});
                end
            end
            if (cyc == 681) begin
                vectors++;
                if (rd_last_ic !== 1'b1 || rd_first_ic !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tag_679 got=last%b first%b exp=last1 first0", rd_last_ic, rd_first_ic);
                end
            end
            drive_cycle(1'b0, 1'b1, 1'b0);
        end
        vectors++;
        if (pulses !== 2704 || done_cnt !== 1 || done_cyc !== 2706) begin
            miscompares++;
            $display("FAIL full_run_counts got=%0d/%0d/%0d exp=2704/1/2706", pulses, done_cnt, done_cyc);
        end
        vectors++;
        if (busy_first !== 1 || busy_last !== 2706) begin
            miscompares++;
            $display("FAIL full_run_busy got=%0d..%0d exp=1..2706", busy_first, busy_last);
        end
    endtask

    task automatic test_stall();
        clear_stats();
        drive_cycle(1'b1, 1'b1, 1'b0);
        run_to_idle(102, 106, -1, 1'b0);
        vectors++;
        if (pulses !== 2704 || done_cnt !== 1 || done_cyc !== 2711) begin
            miscompares++;
            $display("FAIL stall_counts got=%0d/%0d/%0d exp=2704/1/2711", pulses, done_cnt, done_cyc);
        end
        vectors++;
        if (busy_last !== 2711) begin
            miscompares++;
            $display("FAIL stall_busy got=%0d exp=2711", busy_last);
        end
    endtask

    task automatic test_start_ignored();
        clear_stats();
        drive_cycle(1'b1, 1'b1, 1'b0);
        run_to_idle(-1, -2, 500, 1'b1);
        vectors++;
        if (pulses !== 2704 || done_cnt !== 1 || done_cyc !== 2706) begin
            miscompares++;
            $display("FAIL start_busy_counts got=%0d/%0d/%0d exp=2704/1/2706", pulses, done_cnt, done_cyc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done got=busy%b exp=busy0", busy);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        clear_stats();
        drive_cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 1100; k++) begin
            if (cyc >= 1001) break;
            drive_cycle(1'b0, 1'b1, 1'b0);
        end
        drive_cycle(1'b1, 1'b1, 1'b1);
        vectors++;
        if ({busy, done, rd_valid} !== 3'b000 || dut_addrs !== 42'd0 || dut_tag !== 17'd0) begin
            miscompares++;
            $display("FAIL mid_reset got=%b/%h/%h exp=000/0/0", {busy, done, rd_valid}, dut_addrs, dut_tag);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        clear_stats();
        drive_cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (dut_addrs !== 42'd0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_first got=%h v%b b%b exp=0 v0 b1", dut_addrs, rd_valid, busy);
        end
        run_to_idle(-1, -2, -1, 1'b0);
        vectors++;
        if (pulses !== 2704 || done_cyc !== 2706) begin
            miscompares++;
            $display("FAIL restart_counts got=%0d/%0d exp=2704/2706", pulses, done_cyc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dp_ready = 1'b0;
        clear_stats();
        test_reset();
        test_full_run();
        test_stall();
        test_start_ignored();
        test_reset_mid_run();
        drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
